// File: rtl/e_series_calc.sv
// Fixed-point series evaluator for e (mode 0) or 1/e (mode 1), sum of +/-1/k!.
// One restoring-division quotient bit per clock; the run stops early once a term truncates to zero.
module e_series_calc #(
    parameter  int INT_W   = 2,
    parameter  int FRAC_W  = 398,
    parameter  int N_TERMS = 100,
    localparam int ANS_W   = INT_W + FRAC_W,
    localparam int K_W     = $clog2(N_TERMS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [ANS_W-1:0] ans,
    output logic [K_W-1:0]   terms_used
);
    localparam int BC_W = $clog2(ANS_W);
    localparam logic [ANS_W-1:0] ONE    = {{(INT_W-1){1'b0}}, 1'b1, {FRAC_W{1'b0}}};
    localparam logic [BC_W-1:0]  BC_TOP = BC_W'(ANS_W - 1);
    localparam logic [K_W-1:0]   K_LAST = K_W'(N_TERMS - 1);

    typedef enum logic [1:0] {IDLE, DIV, ACC} state_t;

    state_t           state, state_n;
    logic [ANS_W-1:0] acc, acc_n;
    logic [ANS_W-1:0] term, term_n;
    logic [ANS_W-1:0] q, q_n;
    logic [ANS_W-1:0] ans_n;
    logic [ANS_W-1:0] acc_upd;
    logic [K_W-1:0]   k, k_n;
    logic [K_W-1:0]   tu_n;
    logic [K_W:0]     rem, rem_n;
    logic [K_W+1:0]   rem_sh;
    logic [BC_W-1:0]  bitcnt, bitcnt_n;
    logic             mode_l, mode_l_n;
    logic             done_n;

    // Modulo-ANS_W add or subtract; truncation is the only rounding in this design.
    function automatic logic [ANS_W-1:0] acc_step(input logic [ANS_W-1:0] a,
                                                  input logic [ANS_W-1:0] t,
                                                  input logic             sub);
        return sub ? (a - t) : (a + t);
    endfunction

    assign busy = (state != IDLE);

    always_comb begin
        state_n  = state;
        acc_n    = acc;
        term_n   = term;
        q_n      = q;
        k_n      = k;
        rem_n    = rem;
        bitcnt_n = bitcnt;
        mode_l_n = mode_l;
        ans_n    = ans;
        tu_n     = terms_used;
        done_n   = 1'b0;
        rem_sh   = {rem, term[bitcnt]};
        acc_upd  = acc_step(acc, q, mode_l & k[0]);

        case (state)
            IDLE: begin
                if (start && !abort) begin
                    acc_n    = ONE;
                    term_n   = ONE;
                    k_n      = K_W'(1);
                    rem_n    = '0;
                    bitcnt_n = BC_TOP;
                    mode_l_n = mode;
                    state_n  = DIV;
                end
            end
            DIV: begin
                if (abort) begin
                    state_n = IDLE;
                end else begin
                    if (rem_sh >= {2'b00, k}) begin
                        q_n   = {q[ANS_W-2:0], 1'b1};
                        rem_n = (K_W+1)'(rem_sh - {2'b00, k});
                    end else begin
                        q_n   = {q[ANS_W-2:0], 1'b0};
                        rem_n = rem_sh[K_W:0];
                    end
                    if (bitcnt == '0) state_n  = ACC;
                    else              bitcnt_n = bitcnt - BC_W'(1);
                end
            end
            ACC: begin
                if (abort) begin
                    state_n = IDLE;
                end else begin
                    term_n = q;
                    acc_n  = acc_upd;
                    // A zero quotient means every later term is zero too.
                    if (k == K_LAST || q == '0) begin
                        ans_n   = acc_upd;
                        tu_n    = k;
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        k_n      = k + K_W'(1);
                        rem_n    = '0;
                        bitcnt_n = BC_TOP;
                        state_n  = DIV;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            acc        <= '0;
            term       <= '0;
            q          <= '0;
            k          <= '0;
            rem        <= '0;
            bitcnt     <= '0;
            mode_l     <= 1'b0;
            ans        <= '0;
            terms_used <= '0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            acc        <= acc_n;
            term       <= term_n;
            q          <= q_n;
            k          <= k_n;
            rem        <= rem_n;
            bitcnt     <= bitcnt_n;
            mode_l     <= mode_l_n;
            ans        <= ans_n;
            terms_used <= tu_n;
            done       <= done_n;
        end
    end

endmodule

// File: tb/tb_e_series_calc.sv
// Scoreboard bench for e_series_calc: three instances (N_TERMS 4 and 20 at 8 bits, default 400 bits),
// expectations queued at launch and popped by a monitor on each done pulse.
module tb_e_series_calc;

    typedef struct {
        logic [399:0] ans;
        int           terms;
        longint       t0;
        int           lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         start_v [3];
    logic         mode_v  [3];
    logic         abort_v [3];
    logic         busy_v  [3];
    logic         done_v  [3];
    logic [7:0]   ans_a, ans_b;
    logic [399:0] ans_c;
    logic [1:0]   tu_a;
    logic [4:0]   tu_b;
    logic [6:0]   tu_c;
    logic [399:0] ans_v [3];
    logic [6:0]   tu_v  [3];

    assign ans_v[0] = {392'd0, ans_a};
    assign ans_v[1] = {392'd0, ans_b};
    assign ans_v[2] = ans_c;
    assign tu_v[0]  = {5'd0, tu_a};
    assign tu_v[1]  = {2'd0, tu_b};
    assign tu_v[2]  = tu_c;

    e_series_calc #(.INT_W(2), .FRAC_W(6), .N_TERMS(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .mode(mode_v[0]), .abort(abort_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .ans(ans_a), .terms_used(tu_a));

    e_series_calc #(.INT_W(2), .FRAC_W(6), .N_TERMS(20)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .mode(mode_v[1]), .abort(abort_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .ans(ans_b), .terms_used(tu_b));

    e_series_calc dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .mode(mode_v[2]), .abort(abort_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .ans(ans_c), .terms_used(tu_c));

    longint cyc = 0;
    int     checks = 0;
    int     errors = 0;
    int     donec = 0;
    exp_t   sbq [3][$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [399:0] act, input logic [399:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: straight series arithmetic on wide integers, masked to the result width.
    function automatic void model(input int n, input int aw, input int fw, input bit md,
                                  output logic [399:0] a, output int kl);
        logic [399:0] mask, acc, term;
        mask = (aw >= 400) ? '1 : ((400'd1 << aw) - 400'd1);
        term = 400'd1 << fw;
        acc  = term;
        kl   = 0;
        for (int kk = 1; kk < n; kk++) begin
            term = term / 400'(kk);
            if (md && (kk % 2 == 1)) acc = (acc - term) & mask;
            else                     acc = (acc + term) & mask;
            kl = kk;
            if (term == 0) break;
        end
        a = acc;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            if (rst_n && done_v[i]) begin
                if (i == 2) donec++;
                if (sbq[i].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done dut%0d actual=1 required=0", i);
                end else begin
                    e = sbq[i].pop_front();
                    chk($sformatf("ans_dut%0d", i), ans_v[i], e.ans);
                    chk($sformatf("terms_dut%0d", i), 400'(tu_v[i]), 400'(e.terms));
                    chk($sformatf("latency_dut%0d", i), 400'(cyc - e.t0), 400'(e.lat));
                end
            end
        end
    end

    // Returns at the negedge right after the accepting edge E0; mode is scrambled afterwards to
    // confirm it was latched.
    task automatic launch(input int i, input bit md, input logic [399:0] ea, input int et,
                          input int el, input bit repulse);
        @(negedge clk);
        start_v[i] = 1'b1;
        mode_v[i]  = md;
        @(negedge clk);
        start_v[i] = 1'b0;
        mode_v[i]  = 1'($urandom_range(0, 1));
        sbq[i].push_back('{ans: ea, terms: et, t0: cyc, lat: el});
        if (repulse) begin
            repeat ($urandom_range(2, 12)) @(negedge clk);
            start_v[i] = 1'b1;
            mode_v[i]  = ~md;
            @(negedge clk);
            start_v[i] = 1'b0;
        end
    endtask

    task automatic wait_idle(input int i, input int bound);
        for (int n = 0; n < bound && sbq[i].size() != 0; n++) @(negedge clk);
        @(negedge clk);
        checks++;
        if (sbq[i].size() != 0) begin
            errors++;
            $display("FAIL timeout_dut%0d actual=%0d pending required=0", i, sbq[i].size());
            sbq[i].delete();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [399:0] ea;
        int           kl;
        bit           md;
        int           di;

        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            mode_v[i]  = 1'b0;
            abort_v[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_busy%0d", i), 400'(busy_v[i]), 400'd0);
            chk($sformatf("rst_ans%0d", i), ans_v[i], 400'd0);
        end
        chk("rst_done0", 400'(done_v[0]), 400'd0);
        chk("rst_terms0", 400'(tu_v[0]), 400'd0);

        // e with four terms, plus busy window around the done edge
        launch(0, 1'b0, 400'hAA, 3, 27, 1'b0);
        for (int o = 1; o <= 27; o++) begin
            @(negedge clk);
            if (o == 1 || o == 26) chk($sformatf("busy_run_o%0d", o), 400'(busy_v[0]), 400'd1);
            if (o == 27)           chk("busy_after_done", 400'(busy_v[0]), 400'd0);
        end
        wait_idle(0, 100);

        // 1/e with four terms
        launch(0, 1'b1, 400'h16, 3, 27, 1'b0);
        wait_idle(0, 100);

        // early stop at k=5 with twenty terms allowed
        launch(1, 1'b0, 400'hAC, 5, 45, 1'b0);
        wait_idle(1, 200);

        // start re-pulsed mid-run is ignored
        launch(0, 1'b0, 400'hAA, 3, 27, 1'b1);
        wait_idle(0, 100);

        // abort mid-run: no done, previous result retained
        @(negedge clk);
        start_v[0] = 1'b1;
        mode_v[0]  = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (9) @(negedge clk);
        chk("busy_before_abort", 400'(busy_v[0]), 400'd1);
        abort_v[0] = 1'b1;
        @(negedge clk);
        abort_v[0] = 1'b0;
        chk("busy_after_abort", 400'(busy_v[0]), 400'd0);
        chk("ans_after_abort", ans_v[0], 400'hAA);
        chk("terms_after_abort", 400'(tu_v[0]), 400'd3);
        repeat (30) @(negedge clk);

        // abort in IDLE blocks a simultaneous start
        start_v[0] = 1'b1;
        abort_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        abort_v[0] = 1'b0;
        chk("busy_start_with_abort", 400'(busy_v[0]), 400'd0);

        // start in the done cycle begins a new run immediately
        launch(0, 1'b1, 400'h16, 3, 27, 1'b0);
        for (int n = 0; n < 100 && !done_v[0]; n++) @(negedge clk);
        start_v[0] = 1'b1;
        mode_v[0]  = 1'b0;
        @(negedge clk);
        start_v[0] = 1'b0;
        sbq[0].push_back('{ans: 400'hAA, terms: 3, t0: cyc, lat: 27});
        wait_idle(0, 100);

        // randomized runs against the reference model
        for (int r = 0; r < 12; r++) begin
            di = int'($urandom_range(0, 1));
            md = 1'($urandom_range(0, 1));
            model((di == 0) ? 4 : 20, 8, 6, md, ea, kl);
            launch(di, md, ea, kl, kl * 9, 1'($urandom_range(0, 1)));
            wait_idle(di, 200);
            repeat ($urandom_range(0, 4)) @(negedge clk);
        end

        // asynchronous reset mid-run clears outputs at once
        @(negedge clk);
        start_v[0] = 1'b1;
        mode_v[0]  = 1'b0;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (12) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("busy_in_reset", 400'(busy_v[0]), 400'd0);
        chk("done_in_reset", 400'(done_v[0]), 400'd0);
        chk("ans_in_reset", ans_v[0], 400'd0);
        chk("terms_in_reset", 400'(tu_v[0]), 400'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        launch(0, 1'b0, 400'hAA, 3, 27, 1'b0);
        wait_idle(0, 100);

        // full-width default instance
        model(100, 400, 398, 1'b0, ea, kl);
        donec = 0;
        launch(2, 1'b0, ea, kl, kl * 401, 1'b0);
        wait_idle(2, 40000);
        chk("e_top_digits", 400'({2'b00, ans_c[399:370]}), 400'h2B7E1516);
        repeat (5) @(negedge clk);
        chk("done_once_c", 400'(donec), 400'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
